// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction fields and front-end control going into
// the ID/EX register, plus the registered EX-side fields and hazard outputs coming back.
interface id_ex_if;
    // decode side
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;
    logic [4:0]  if_id_rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [1:0]  wb_ctrl;
    logic [1:0]  mem_ctrl;
    logic [3:0]  ex_ctrl;
    logic        ex_flush;
    logic        hold;
    // execute side
    logic        id_ex_valid;
    logic [31:0] id_ex_pc;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic [1:0]  id_ex_wb;
    logic [1:0]  id_ex_mem;
    logic [3:0]  id_ex_ex;
    logic        pc_write;
    logic        if_id_write;
    logic        load_use_stall;
    logic [31:0] stall_count;

    // the pipeline register itself
    modport slave (
        input  if_id_valid, if_id_pc, if_id_rs1, if_id_rs2, if_id_rd,
               rs1_data, rs2_data, imm, wb_ctrl, mem_ctrl, ex_ctrl, ex_flush, hold,
        output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_wb, id_ex_mem, id_ex_ex,
               pc_write, if_id_write, load_use_stall, stall_count
    );

    // the decode stage / surrounding core
    modport master (
        output if_id_valid, if_id_pc, if_id_rs1, if_id_rs2, if_id_rd,
               rs1_data, rs2_data, imm, wb_ctrl, mem_ctrl, ex_ctrl, ex_flush, hold,
        input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_wb, id_ex_mem, id_ex_ex,
               pc_write, if_id_write, load_use_stall, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection. Inserts one bubble when the
// instruction in decode reads the destination of a load sitting in EX, squashes on a
// taken branch, and freezes completely under a backend hold.
module id_ex_stage (
    input  logic clk,
    input  logic rst_n,
    id_ex_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic                     vld_p1;
    logic        [DATA_W-1:0] pc_p1;
    logic        [DATA_W-1:0] rs1_data_p1;
    logic        [DATA_W-1:0] rs2_data_p1;
    logic        [DATA_W-1:0] imm_p1;
    logic        [REG_W-1:0]  rs1_p1;
    logic        [REG_W-1:0]  rs2_p1;
    logic        [REG_W-1:0]  rd_p1;
    logic        [1:0]        wb_p1;
    logic        [1:0]        mem_p1;
    logic        [3:0]        ex_p1;
    logic        [31:0]       stall_cnt_p1;

    logic lu;
    logic stall;
    logic front_write;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Hazard detect: a live load in EX writing a non-zero register that decode reads.
    // Flush and hold both override the stall so the redirect / freeze is not delayed.
    always_comb begin
        lu = vld_p1 & mem_p1[1] & (rd_p1 != '0) & bus.if_id_valid &
             ((rd_p1 == bus.if_id_rs1) | (rd_p1 == bus.if_id_rs2));
        stall       = lu & ~bus.ex_flush & ~bus.hold;
        front_write = ~bus.hold & ~stall;
    end

    // ---- ID -> EX boundary: hold > flush > load-use bubble > normal capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            wb_p1       <= '0;
            mem_p1      <= '0;
            ex_p1       <= '0;
        end else if (!bus.hold) begin
            if (bus.ex_flush || stall) begin
                vld_p1      <= 1'b0;
                pc_p1       <= '0;
                rs1_data_p1 <= '0;
                rs2_data_p1 <= '0;
                imm_p1      <= '0;
                rs1_p1      <= '0;
                rs2_p1      <= '0;
                rd_p1       <= '0;
                wb_p1       <= '0;
                mem_p1      <= '0;
                ex_p1       <= '0;
            end else begin
                vld_p1      <= bus.if_id_valid;
                pc_p1       <= bus.if_id_pc;
                rs1_data_p1 <= bus.rs1_data;
                rs2_data_p1 <= bus.rs2_data;
                imm_p1      <= bus.imm;
                rs1_p1      <= bus.if_id_rs1;
                rs2_p1      <= bus.if_id_rs2;
                rd_p1       <= bus.if_id_rd;
                // an empty slot must never write the register file or memory
                wb_p1       <= bus.if_id_valid ? bus.wb_ctrl  : 2'b00;
                mem_p1      <= bus.if_id_valid ? bus.mem_ctrl : 2'b00;
                ex_p1       <= bus.ex_ctrl;
            end
        end
    end

    // Count bubble-inserting cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_p1 <= '0;
        end else if (stall) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign bus.id_ex_valid    = vld_p1;
    assign bus.id_ex_pc       = pc_p1;
    assign bus.id_ex_rs1_data = rs1_data_p1;
    assign bus.id_ex_rs2_data = rs2_data_p1;
    assign bus.id_ex_imm      = imm_p1;
    assign bus.id_ex_rs1      = rs1_p1;
    assign bus.id_ex_rs2      = rs2_p1;
    assign bus.id_ex_rd       = rd_p1;
    assign bus.id_ex_wb       = wb_p1;
    assign bus.id_ex_mem      = mem_p1;
    assign bus.id_ex_ex       = ex_p1;
    assign bus.pc_write       = front_write;
    assign bus.if_id_write    = front_write;
    assign bus.load_use_stall = stall;
    assign bus.stall_count    = stall_cnt_p1;
endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed hazard scenarios with literal expectations plus a
// randomized stream checked every cycle against an instruction-level reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [3:0]  ex;
    } slot_t;

    slot_t       cur;        // instruction presented by decode
    logic        cur_flush;
    logic        cur_hold;
    slot_t       m;          // instruction the model believes is in EX
    logic [31:0] m_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does the instruction in decode need the result of a load still in EX?
    function automatic logic model_stall(input slot_t ex_slot, input slot_t id_slot,
                                         input logic flush, input logic hold);
        logic ex_loads_reg;
        logic id_reads_it;
        ex_loads_reg = ex_slot.valid && ex_slot.mem[1] && (ex_slot.rd != 5'd0);
        id_reads_it  = id_slot.valid && (id_slot.rs1 == ex_slot.rd || id_slot.rs2 == ex_slot.rd);
        return ex_loads_reg && id_reads_it && !flush && !hold;
    endfunction

    task automatic drive();
        bus.if_id_valid = cur.valid;
        bus.if_id_pc    = cur.pc;
        bus.if_id_rs1   = cur.rs1;
        bus.if_id_rs2   = cur.rs2;
        bus.if_id_rd    = cur.rd;
        bus.rs1_data    = cur.rs1d;
        bus.rs2_data    = cur.rs2d;
        bus.imm         = cur.imm;
        bus.wb_ctrl     = cur.wb;
        bus.mem_ctrl    = cur.mem;
        bus.ex_ctrl     = cur.ex;
        bus.ex_flush    = cur_flush;
        bus.hold        = cur_hold;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] wb,
                             input logic [1:0] mem, input logic [3:0] ex);
        cur.valid = v;  cur.pc = pc;  cur.rs1 = rs1; cur.rs2 = rs2; cur.rd = rd;
        cur.rs1d = $urandom; cur.rs2d = $urandom; cur.imm = $urandom;
        cur.wb = wb; cur.mem = mem; cur.ex = ex;
        drive();
    endtask

    task automatic set_random();
        cur.valid = ($urandom_range(0, 9) != 0);
        cur.pc    = $urandom;
        cur.rs1   = 5'($urandom_range(0, 3));
        cur.rs2   = 5'($urandom_range(0, 3));
        cur.rd    = 5'($urandom_range(0, 3));
        cur.rs1d  = $urandom;
        cur.rs2d  = $urandom;
        cur.imm   = $urandom;
        cur.wb    = 2'($urandom_range(0, 3));
        cur.mem   = 2'($urandom_range(0, 3));
        cur.ex    = 4'($urandom_range(0, 15));
        cur_flush = ($urandom_range(0, 9) == 0);
        cur_hold  = ($urandom_range(0, 9) == 0);
        drive();
    endtask

    // Check every DUT output against the model for the current cycle.
    task automatic compare_all();
        logic s;
        s = model_stall(m, cur, cur_flush, cur_hold);
        chk("id_ex_valid",    32'(bus.id_ex_valid),    32'(m.valid));
        chk("id_ex_pc",       bus.id_ex_pc,            m.pc);
        chk("id_ex_rs1_data", bus.id_ex_rs1_data,      m.rs1d);
        chk("id_ex_rs2_data", bus.id_ex_rs2_data,      m.rs2d);
        chk("id_ex_imm",      bus.id_ex_imm,           m.imm);
        chk("id_ex_rs1",      32'(bus.id_ex_rs1),      32'(m.rs1));
        chk("id_ex_rs2",      32'(bus.id_ex_rs2),      32'(m.rs2));
        chk("id_ex_rd",       32'(bus.id_ex_rd),       32'(m.rd));
        chk("id_ex_wb",       32'(bus.id_ex_wb),       32'(m.wb));
        chk("id_ex_mem",      32'(bus.id_ex_mem),      32'(m.mem));
        chk("id_ex_ex",       32'(bus.id_ex_ex),       32'(m.ex));
        chk("load_use_stall", 32'(bus.load_use_stall), 32'(s));
        chk("pc_write",       32'(bus.pc_write),       32'(!cur_hold && !s));
        chk("if_id_write",    32'(bus.if_id_write),    32'(!cur_hold && !s));
        chk("stall_count",    bus.stall_count,         m_cnt);
    endtask

    // Advance the model by one clock using the inputs held over that edge.
    task automatic model_update();
        logic s;
        s = model_stall(m, cur, cur_flush, cur_hold);
        if (!cur_hold) begin
            if (cur_flush || s) begin
                m = '0;
            end else begin
                m = cur;
                if (!cur.valid) begin
                    m.wb  = 2'b00;
                    m.mem = 2'b00;
                end
            end
        end
        if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cur = '0; cur_flush = 1'b0; cur_hold = 1'b0;
        drive();
        m = '0; m_cnt = 32'd0;
        #2;
        compare_all();
        chk("reset_valid",    32'(bus.id_ex_valid), 32'd0);
        chk("reset_count",    bus.stall_count, 32'd0);
        chk("reset_pc_write", 32'(bus.pc_write), 32'd1);
        chk("reset_lus",      32'(bus.load_use_stall), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // load-use on rs1: lw x5 in EX, add x6,x5,x7 in ID
        set_instr(1'b1, 32'h40, 5'd1, 5'd2, 5'd5, 2'b11, 2'b10, 4'b1000);
        step();
        set_instr(1'b1, 32'h44, 5'd5, 5'd7, 5'd6, 2'b10, 2'b00, 4'b0000);
        #1;
        chk("lu_stall",       32'(bus.load_use_stall), 32'd1);
        chk("lu_pc_write",    32'(bus.pc_write), 32'd0);
        chk("lu_if_id_write", 32'(bus.if_id_write), 32'd0);
        step();
        chk("lu_bubble_valid", 32'(bus.id_ex_valid), 32'd0);
        chk("lu_bubble_wb",    32'(bus.id_ex_wb), 32'd0);
        chk("lu_bubble_rd",    32'(bus.id_ex_rd), 32'd0);
        chk("lu_count",        bus.stall_count, 32'd1);
        chk("lu_once",         32'(bus.load_use_stall), 32'd0);
        step();
        chk("lu_dep_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("lu_dep_rs1",   32'(bus.id_ex_rs1), 32'd5);
        chk("lu_dep_rd",    32'(bus.id_ex_rd), 32'd6);
        chk("lu_dep_count", bus.stall_count, 32'd1);

        // load to x0 never stalls
        set_instr(1'b1, 32'h48, 5'd1, 5'd2, 5'd0, 2'b11, 2'b10, 4'b1000);
        step();
        set_instr(1'b1, 32'h4C, 5'd0, 5'd0, 5'd1, 2'b10, 2'b00, 4'b0000);
        #1;
        chk("x0_no_stall", 32'(bus.load_use_stall), 32'd0);
        chk("x0_pc_write", 32'(bus.pc_write), 32'd1);
        step();
        chk("x0_no_bubble", 32'(bus.id_ex_rd), 32'd1);

        // non-load producer never stalls
        set_instr(1'b1, 32'h50, 5'd1, 5'd2, 5'd5, 2'b10, 2'b00, 4'b0000);
        step();
        set_instr(1'b1, 32'h54, 5'd5, 5'd3, 5'd6, 2'b10, 2'b00, 4'b0000);
        #1;
        chk("alu_no_stall", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("alu_no_bubble", 32'(bus.id_ex_rd), 32'd6);

        // flush beats load-use: no stall, bubble, counter unchanged
        set_instr(1'b1, 32'h58, 5'd1, 5'd2, 5'd5, 2'b11, 2'b10, 4'b1000);
        step();
        set_instr(1'b1, 32'h5C, 5'd3, 5'd5, 5'd6, 2'b10, 2'b00, 4'b0000);
        cur_flush = 1'b1; drive();
        #1;
        chk("flush_pc_write", 32'(bus.pc_write), 32'd1);
        chk("flush_no_stall", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("flush_bubble", 32'(bus.id_ex_valid), 32'd0);
        chk("flush_count",  bus.stall_count, 32'd1);
        cur_flush = 1'b0; drive();

        // hold for three cycles, flush on the middle one; flush lands after hold drops
        set_instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd9, 2'b11, 2'b10, 4'b1000);
        step();
        set_instr(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 2'b10, 2'b00, 4'b0000);
        cur_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_flush = (i == 1);
            drive();
            #1;
            chk("hold_pc_write",    32'(bus.pc_write), 32'd0);
            chk("hold_if_id_write", 32'(bus.if_id_write), 32'd0);
            step();
            chk("hold_pc", bus.id_ex_pc, 32'h100);
            chk("hold_rd", 32'(bus.id_ex_rd), 32'd9);
        end
        cur_hold = 1'b0; cur_flush = 1'b1; drive();
        step();
        chk("hold_then_flush", 32'(bus.id_ex_valid), 32'd0);
        cur_flush = 1'b0; drive();

        // counter saturation
        set_instr(1'b1, 32'h300, 5'd1, 5'd2, 5'd5, 2'b11, 2'b10, 4'b1000);
        step();
        set_instr(1'b1, 32'h304, 5'd5, 5'd5, 5'd6, 2'b10, 2'b00, 4'b0000);
        #1 force dut.stall_cnt_p1 = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_p1;
        m_cnt = 32'hFFFF_FFFE;
        step();
        chk("sat_reach", bus.stall_count, 32'hFFFF_FFFF);
        set_instr(1'b1, 32'h308, 5'd1, 5'd2, 5'd5, 2'b11, 2'b10, 4'b1000);
        step();
        set_instr(1'b1, 32'h30C, 5'd1, 5'd5, 5'd6, 2'b10, 2'b01, 4'b0000);
        #1;
        chk("sat_store_stall", 32'(bus.load_use_stall), 32'd1);
        step();
        chk("sat_hold", bus.stall_count, 32'hFFFF_FFFF);

        // randomized stream
        for (int i = 0; i < 1500; i++) begin
            set_random();
            step();
        end

        // reset mid-stream with a writing instruction in EX
        cur_hold = 1'b0; cur_flush = 1'b0;
        set_instr(1'b1, 32'h400, 5'd1, 5'd2, 5'd4, 2'b10, 2'b00, 4'b0000);
        step();
        chk("pre_reset_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("pre_reset_wb",    32'(bus.id_ex_wb), 32'd2);
        #1 rst_n = 1'b0;
        m = '0; m_cnt = 32'd0;
        #1;
        chk("mid_reset_valid",    32'(bus.id_ex_valid), 32'd0);
        chk("mid_reset_wb",       32'(bus.id_ex_wb), 32'd0);
        chk("mid_reset_count",    bus.stall_count, 32'd0);
        chk("mid_reset_pc_write", 32'(bus.pc_write), 32'd1);
        compare_all();
        #1 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
